psum_accum_bank: RTL



---
 rtl/psum_accum_bank.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/psum_accum_bank.sv
// Psum accumulator bank: lane-wise saturating read-modify-write store with a 2-stage
// forwarding pipeline, clear, drain/done tracking. Optional macro PSUM_ACC_RELU_EN.
module psum_accum_bank #(
  parameter  int psum_bw  = 16,
  parameter  int col      = 8,
  parameter  int len_onij = 16,
  localparam int AW       = (len_onij > 1) ? $clog2(len_onij) : 1,
  localparam int DW       = col * psum_bw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] psum_data_i,
  input  logic [AW-1:0] psum_addr_i,
  input  logic          psum_valid_i,
  input  logic          clear_i,
  input  logic          conv_complete_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          sat_o
);

  localparam logic [AW:0]        LEN_W    = (AW+1)'(len_onij);
  localparam logic [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {
    ACC,
    DRAIN,
    DONE
  } state_t;

  state_t              r_state;
  logic [DW-1:0]       r_mem [len_onij];
  logic [len_onij-1:0] r_valid;

  logic                r_s1_v;
  logic [AW-1:0]       r_s1_addr;
  logic [DW-1:0]       r_s1_data;
  logic                r_s2_v;
  logic [AW-1:0]       r_s2_addr;
  logic [DW-1:0]       r_s2_old;
  logic [DW-1:0]       r_s2_new;

  logic [DW-1:0]       r_rd_data;
  logic                r_rd_valid;
  logic                r_sat;
  logic                r_done;

  logic                w_wr_in_range;
  logic                w_rd_in_range;
  logic                w_s2_commit;
  logic                w_busy;
  logic [DW-1:0]       w_s2_sum;
  logic                w_s2_clamp;
  logic [psum_bw:0]    w_lane_sum;
  logic [DW-1:0]       w_fetch;
  logic [DW-1:0]       w_rd_raw;
  logic [DW-1:0]       w_rd_final;

  assign w_wr_in_range = ({1'b0, psum_addr_i} < LEN_W);
  assign w_rd_in_range = ({1'b0, rd_addr_i} < LEN_W);
  assign w_s2_commit   = r_s2_v & ~clear_i;
  assign w_busy        = r_s1_v | r_s2_v;

  // One extra bit per lane exposes overflow: top two bits differ only on a wrap.
  always_comb begin
    w_s2_sum   = '0;
    w_s2_clamp = 1'b0;
    w_lane_sum = '0;
    for (int unsigned k = 0; k < col; k++) begin
      w_lane_sum = {r_s2_old[k*psum_bw + psum_bw - 1], r_s2_old[k*psum_bw +: psum_bw]}
                 + {r_s2_new[k*psum_bw + psum_bw - 1], r_s2_new[k*psum_bw +: psum_bw]};
      if (w_lane_sum[psum_bw] != w_lane_sum[psum_bw-1]) begin
        w_s2_clamp = 1'b1;
        w_s2_sum[k*psum_bw +: psum_bw] = w_lane_sum[psum_bw] ? LANE_MIN : LANE_MAX;
      end else begin
        w_s2_sum[k*psum_bw +: psum_bw] = w_lane_sum[psum_bw-1:0];
      end
    end
  end

  // S2 result is forwarded so back-to-back beats to one entry chain exactly.
  always_comb begin
    w_fetch = '0;
    if (r_s2_v && (r_s2_addr == r_s1_addr)) begin
      w_fetch = w_s2_sum;
    end else if (r_valid[r_s1_addr]) begin
      w_fetch = r_mem[r_s1_addr];
    end
  end

  always_comb begin
    w_rd_raw = '0;
    if (w_s2_commit && (r_s2_addr == rd_addr_i)) begin
      w_rd_raw = w_s2_sum;
    end else if (w_rd_in_range && r_valid[rd_addr_i]) begin
      w_rd_raw = r_mem[rd_addr_i];
    end
  end

  always_comb begin
    w_rd_final = w_rd_raw;
`ifdef PSUM_ACC_RELU_EN
    for (int unsigned k = 0; k < col; k++) begin
      if (w_rd_raw[k*psum_bw + psum_bw - 1]) begin
        w_rd_final[k*psum_bw +: psum_bw] = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_s2_commit) begin
      r_mem[r_s2_addr] <= w_s2_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v    <= 1'b0;
      r_s1_addr <= '0;
      r_s1_data <= '0;
      r_s2_v    <= 1'b0;
      r_s2_addr <= '0;
      r_s2_old  <= '0;
      r_s2_new  <= '0;
    end else begin
      r_s1_v <= psum_valid_i & w_wr_in_range;
      if (psum_valid_i) begin
        r_s1_addr <= psum_addr_i;
        r_s1_data <= psum_data_i;
      end
      r_s2_v <= r_s1_v & ~clear_i;
      if (r_s1_v) begin
        r_s2_addr <= r_s1_addr;
        r_s2_old  <= w_fetch;
        r_s2_new  <= r_s1_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_sat   <= 1'b0;
      r_done  <= 1'b0;
      r_state <= ACC;
    end else if (clear_i) begin
      r_valid <= '0;
      r_sat   <= 1'b0;
      r_done  <= 1'b0;
      r_state <= ACC;
    end else begin
      if (r_s2_v) begin
        r_valid[r_s2_addr] <= 1'b1;
        if (w_s2_clamp) begin
          r_sat <= 1'b1;
        end
      end
      case (r_state)
        ACC: begin
          if (conv_complete_i) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!w_busy && !psum_valid_i) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          if (psum_valid_i) begin
            r_state <= ACC;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ACC;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en_i;
      if (rd_en_i) begin
        r_rd_data <= w_rd_final;
      end
    end
  end

  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;
  assign busy_o     = w_busy;
  assign done_o     = r_done;
  assign sat_o      = r_sat;

endmodule
